cnn_layer_accel_weight_loader: RTL and testbench
================================================

// Module: cnn_layer_accel_weight_loader
// PURPOSE
//  Feeds the CE weight table during layer configuration. Takes a 16-bit weight stream (valid/ready) from the
//  config FIFO and produces job_accept, config_mode, wht_config_wren and wht_config_data for the weight table.
//  It delivers (num_kernels+1) kernels of C_KERNEL_WORDS words each, then signals done. It sits between the
//  job-fetch logic and cnn_layer_accel_weight_table_top, one instance per CE.
// PARAMETERS
//  C_KERNEL_WORDS        9   weights per 3x3 kernel; matches KERNEL_3x3_COUNT_FULL_MINUS_1 + 1
//  C_CLG2_MAX_KERNELS    6   width of num_kernels; equals clog2(`MAX_BRAM_3x3_KERNELS)
// PORTS
//  clk               in   1    clock
//  rst               in   1    synchronous, active-high reset
//  start             in   1    1-cycle pulse that begins a load; ignored unless the state is IDLE
//  num_kernels       in   C_CLG2_MAX_KERNELS  last kernel index (kernels loaded = num_kernels+1); sampled on start
//  s_valid           in   1    weight stream valid
//  s_ready           out  1    weight stream ready
//  s_data            in   16   weight word
//  job_accept        out  1    1-cycle pulse that clears the weight table counters
//  config_mode       out  1    high from ACCEPT through FLUSH
//  wht_config_wren   out  1    weight table write strobe
//  wht_config_data   out  16   weight table write data
//  busy              out  1    high in any state except IDLE
//  done              out  1    1-cycle pulse when the load is complete
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; word_cnt=0; kern_cnt=0.
//  FSM (registered): IDLE -start-> ACCEPT -> LOAD -last word accepted-> FLUSH -> DONE -> IDLE.
//   ACCEPT: job_accept=1 and config_mode=1 for exactly 1 cycle. num_kernels is latched on the start cycle.
//   LOAD: s_ready=1. No other state asserts s_ready. A beat is a cycle with s_valid&&s_ready.
//   Each beat gives wht_config_wren=1 and wht_config_data=s_data on the next cycle (fixed 1-cycle latency,
//   registered). wht_config_data holds its last value when wren=0.
//   word_cnt counts beats 0..C_KERNEL_WORDS-1 and wraps to 0, incrementing kern_cnt.
//   The beat with word_cnt==C_KERNEL_WORDS-1 && kern_cnt==latched num_kernels goes to FLUSH. s_ready is 0 from
//   the next cycle, so no extra word is consumed.
//   FLUSH: 1 cycle while the final wren is issued; config_mode stays 1.
//   DONE: done=1, config_mode=0, 1 cycle.
//  Stream stalls: s_valid low in LOAD produces no wren and holds the counters. Gaps of any length are legal.
//  Total wren count per job = (num_kernels+1)*C_KERNEL_WORDS, exactly; consecutive beats give back-to-back wren.
//  num_kernels=0 loads one kernel. The maximum value loads 2^C_CLG2_MAX_KERNELS kernels; the counter must not overflow.
//  start while busy: ignored, with no effect on counters or latched values. start in the same cycle as rst: reset wins.
//  Reset mid-operation: returns to IDLE next cycle and clears all outputs; no pending wren is issued afterwards.
//  The weight table sees job_accept strictly before the first wren (at least 1 cycle gap).
// CONFIGURATION
//  WHT_LOADER_CHECKSUM_EN defined: adds output wht_checksum[15:0].
//   wht_checksum is the modulo-2^16 sum of all written words. It clears to 0 in ACCEPT and on rst, and is stable
//   from the DONE cycle until the next ACCEPT.
//  WHT_LOADER_CHECKSUM_EN undefined: the port and its adder are absent; all other behaviour is identical.
// TESTING
//  num_kernels=0, 9 words 1..9 with s_valid held high -> job_accept, then 9 consecutive wren with data 1..9,
//   done 2 cycles after the last beat; checksum=45 when enabled.
//  num_kernels=3, random s_valid gaps -> exactly 36 wren, in order, and s_ready=0 after the 36th beat.
//  Extra words queued after the last kernel -> never accepted: s_ready=0, s_valid stays high, no 37th wren.
//  start pulsed again during LOAD -> ignored; counts and latched num_kernels unchanged; exactly one done.
//  rst asserted after 5 beats -> all outputs 0 next cycle, state IDLE. A new start then loads cleanly from
//   word 0 and begins with a fresh job_accept.
//  Max num_kernels with words 0xFFFF -> 2^C_CLG2_MAX_KERNELS*9 wren; checksum wraps mod 2^16 and matches the model.

Source files
------------

// File: rtl/cnn_layer_accel_weight_loader.sv
// Weight-table loader: streams (num_kernels+1) kernels of C_KERNEL_WORDS words into the CE weight table.
// Optional build macro WHT_LOADER_CHECKSUM_EN adds a mod-2^16 running sum of written words (wht_checksum).
//
//  state  | meaning
//  IDLE   | waiting for start
//  ACCEPT | job_accept pulse, counters cleared
//  LOAD   | s_ready high, each beat becomes a wren on the next cycle
//  FLUSH  | final wren on the table port
//  DONE   | done pulse, config_mode dropped
module cnn_layer_accel_weight_loader #(
    parameter int C_KERNEL_WORDS     = 9,
    parameter int C_CLG2_MAX_KERNELS = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   s_data,
    output logic                          job_accept,
    output logic                          config_mode,
    output logic                          wht_config_wren,
    output logic [15:0]                   wht_config_data,
    output logic                          busy,
    output logic                          done
`ifdef WHT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]                   wht_checksum
`endif
);

    localparam int WCW = (C_KERNEL_WORDS > 1) ? $clog2(C_KERNEL_WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(C_KERNEL_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        LOAD   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                        state_q;
    logic [WCW-1:0]                word_cnt_q;
    logic [C_CLG2_MAX_KERNELS-1:0] kern_cnt_q;
    logic [C_CLG2_MAX_KERNELS-1:0] num_q;
    logic                          s_ready_q;
    logic                          job_accept_q;
    logic                          config_mode_q;
    logic                          wren_q;
    logic [15:0]                   data_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          beat;

    assign beat = s_valid && s_ready_q;

    // Outputs are registered against the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            kern_cnt_q    <= '0;
            num_q         <= '0;
            s_ready_q     <= 1'b0;
            job_accept_q  <= 1'b0;
            config_mode_q <= 1'b0;
            wren_q        <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            job_accept_q <= 1'b0;
            done_q       <= 1'b0;
            wren_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= ACCEPT;
                        num_q         <= num_kernels;
                        word_cnt_q    <= '0;
                        kern_cnt_q    <= '0;
                        job_accept_q  <= 1'b1;
                        config_mode_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                ACCEPT: begin
                    state_q   <= LOAD;
                    s_ready_q <= 1'b1;
                end
                LOAD: begin
                    if (beat) begin
                        wren_q <= 1'b1;
                        data_q <= s_data;
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_q <= '0;
                            // Leave before kern_cnt_q would step past num_q, so it never wraps.
                            if (kern_cnt_q == num_q) begin
                                state_q   <= FLUSH;
                                s_ready_q <= 1'b0;
                            end else begin
                                kern_cnt_q <= kern_cnt_q + 1'b1;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state_q       <= DONE;
                    config_mode_q <= 1'b0;
                    done_q        <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    s_ready_q     <= 1'b0;
                    config_mode_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

`ifdef WHT_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;
    logic [15:0] checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = '0;
        end else if (state_q == LOAD && beat) begin
            checksum_d = checksum_q + s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign wht_checksum = checksum_q;
`endif

    assign s_ready         = s_ready_q;
    assign job_accept      = job_accept_q;
    assign config_mode     = config_mode_q;
    assign wht_config_wren = wren_q;
    assign wht_config_data = data_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Directed bench for cnn_layer_accel_weight_loader: job sequencing, stalls, overrun, restart and reset.
module tb_cnn_layer_accel_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  num_kernels;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        job_accept;
    logic        config_mode;
    logic        wht_config_wren;
    logic [15:0] wht_config_data;
    logic        busy;
    logic        done;
`ifdef WHT_LOADER_CHECKSUM_EN
    logic [15:0] wht_checksum;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cnn_layer_accel_weight_loader #(
        .C_KERNEL_WORDS     (9),
        .C_CLG2_MAX_KERNELS (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_kernels     (num_kernels),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .job_accept      (job_accept),
        .config_mode     (config_mode),
        .wht_config_wren (wht_config_wren),
        .wht_config_data (wht_config_data),
        .busy            (busy),
        .done            (done)
`ifdef WHT_LOADER_CHECKSUM_EN
        ,
        .wht_checksum    (wht_checksum)
`endif
    );

    always #5 clk = ~clk;

    // Passive monitor, sampled on the falling edge.
    int          cyc = 0;
    logic [15:0] got_q[$];
    int          wcyc_q[$];
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wht_config_wren) begin
            got_q.push_back(wht_config_data);
            wcyc_q.push_back(cyc);
        end
        if (job_accept) begin
            acc_cnt = acc_cnt + 1;
            acc_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".s_ready"},     {31'd0, s_ready},         32'd0);
        chk({tag, ".job_accept"},  {31'd0, job_accept},      32'd0);
        chk({tag, ".config_mode"}, {31'd0, config_mode},     32'd0);
        chk({tag, ".wren"},        {31'd0, wht_config_wren}, 32'd0);
        chk({tag, ".data"},        {16'd0, wht_config_data}, 32'd0);
        chk({tag, ".busy"},        {31'd0, busy},            32'd0);
        chk({tag, ".done"},        {31'd0, done},            32'd0);
`ifdef WHT_LOADER_CHECKSUM_EN
        chk({tag, ".checksum"},    {16'd0, wht_checksum},    32'd0);
`endif
    endtask

    // Caller sits just after a rising edge; returns just after the edge that took the beat.
    task automatic push_word(input logic [15:0] d, input int gap);
        int t;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 200) begin
                chk("beat_timeout", t, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [5:0] nk);
        num_kernels = nk;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", {31'd0, (done_cnt == d0)}, 32'd0);
    endtask

    // Full job: nk+1 kernels, data base+i (or 0xFFFF), random gaps up to gapmax, optional overrun.
    task automatic run_job(input string tag, input logic [5:0] nk, input logic [15:0] base,
                           input bit ffff, input int gapmax, input bit extra);
        int          b;
        int          a0;
        int          d0;
        int          n;
        int          bad;
        int          m;
        logic [15:0] sum;
        logic [15:0] d;
        logic [15:0] exp_q[$];
        b   = got_q.size();
        a0  = acc_cnt;
        d0  = done_cnt;
        n   = (int'(nk) + 1) * 9;
        sum = 16'd0;
        pulse_start(nk);
        for (int i = 0; i < n; i++) begin
            d = ffff ? 16'hFFFF : base + 16'(i);
            exp_q.push_back(d);
            sum = sum + d;
            push_word(d, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
        if (extra) begin
            s_data = 16'hDEAD;
            @(negedge clk);
            chk({tag, ".ready_low_after_last"}, {31'd0, s_ready}, 32'd0);
        end else begin
            s_valid = 1'b0;
        end
        wait_done(d0);
`ifdef WHT_LOADER_CHECKSUM_EN
        chk({tag, ".checksum_at_done"}, {16'd0, wht_checksum}, {16'd0, sum});
`endif
        repeat (4) @(negedge clk);
        if (extra) chk({tag, ".ready_low_idle"}, {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        chk({tag, ".wren_count"}, got_q.size() - b, n);
        bad = 0;
        m = (got_q.size() - b < n) ? got_q.size() - b : n;
        for (int i = 0; i < m; i++) begin
            if (got_q[b + i] !== exp_q[i]) bad++;
        end
        chk({tag, ".data_order_errors"}, bad, 32'd0);
        chk({tag, ".accepts"}, acc_cnt - a0, 32'd1);
        chk({tag, ".dones"}, done_cnt - d0, 32'd1);
        if (m > 0) begin
            chk({tag, ".accept_before_wren"}, {31'd0, (wcyc_q[b] - acc_cyc >= 2)}, 32'd1);
            chk({tag, ".done_after_last_wren"}, done_cyc - wcyc_q[b + m - 1], 32'd1);
            if (gapmax == 0) chk({tag, ".back_to_back"}, wcyc_q[b + m - 1] - wcyc_q[b], n - 1);
        end
`ifdef WHT_LOADER_CHECKSUM_EN
        chk({tag, ".checksum_stable"}, {16'd0, wht_checksum}, {16'd0, sum});
`endif
        chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        rst         = 1'b1;
        start       = 1'b0;
        num_kernels = 6'd0;
        s_valid     = 1'b0;
        s_data      = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ACCEPT cycle shape
        pulse_start(6'd0);
        @(negedge clk);
        chk("accept.job_accept",  {31'd0, job_accept},  32'd1);
        chk("accept.config_mode", {31'd0, config_mode}, 32'd1);
        chk("accept.busy",        {31'd0, busy},        32'd1);
        chk("accept.s_ready",     {31'd0, s_ready},     32'd0);
        @(negedge clk);
        chk("load.job_accept",    {31'd0, job_accept},  32'd0);
        chk("load.s_ready",       {31'd0, s_ready},     32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job("one_kernel", 6'd0, 16'd1, 1'b0, 0, 1'b0);
        run_job("gaps_overrun", 6'd3, 16'h1000, 1'b0, 3, 1'b1);

        // start during LOAD must not relatch num_kernels or restart
        begin
            int a0;
            int d0;
            int b;
            b  = got_q.size();
            a0 = acc_cnt;
            d0 = done_cnt;
            pulse_start(6'd1);
            for (int i = 0; i < 4; i++) push_word(16'h2000 + 16'(i), 0);
            s_valid = 1'b0;
            pulse_start(6'd5);
            for (int i = 4; i < 18; i++) push_word(16'h2000 + 16'(i), 1);
            s_valid = 1'b0;
            wait_done(d0);
            repeat (6) @(negedge clk);
            chk("restart_ignored.wren_count", got_q.size() - b, 32'd18);
            chk("restart_ignored.accepts", acc_cnt - a0, 32'd1);
            chk("restart_ignored.dones", done_cnt - d0, 32'd1);
            if (got_q.size() - b >= 18)
                chk("restart_ignored.last_word", {16'd0, got_q[b + 17]}, 32'h2011);
            @(posedge clk);
            #1;
        end

        // reset after 5 beats, with start in the reset cycle
        w0 = got_q.size();
        pulse_start(6'd2);
        for (int i = 0; i < 5; i++) push_word(16'd200 + 16'(i), 0);
        s_valid = 1'b0;
        rst     = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_reset.busy_stays_low", {31'd0, busy}, 32'd0);
        chk("mid_reset.wren_count", got_q.size() - w0, 32'd5);
        @(posedge clk);
        #1;
        run_job("after_reset", 6'd0, 16'd100, 1'b0, 0, 1'b0);

        run_job("max_ffff", 6'd63, 16'd0, 1'b1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
